// File: rtl/ofmap_deskew_collector_pkg.sv
// Shared constants and FSM state encoding for the ofmap deskew collector.
package ofmap_pkg;

  localparam int unsigned MAC_COL_DEFAULT        = 16;
  localparam int unsigned OFMAP_BITWIDTH_DEFAULT = 32;
  localparam int unsigned FIFO_DEPTH_DEFAULT     = 8;
  localparam int unsigned ROW_CNT_W_DEFAULT      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ofmap_deskew_collector_if.sv
// Skewed column input from the MAC array plus the row-vector valid/ready output.
interface ofmap_deskew_collector_if
  import ofmap_pkg::*;
#(
  parameter int unsigned MAC_COL        = MAC_COL_DEFAULT,
  parameter int unsigned OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEFAULT
);

  logic [MAC_COL-1:0]                     ofmap_valid_in;
  logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] ofmap_data_in;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] out_data;

  modport master (
    output ofmap_valid_in, ofmap_data_in, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  ofmap_valid_in, ofmap_data_in, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/ofmap_row_fifo.sv
// Synchronous row-vector FIFO; simultaneous push and pop is accepted when full.
module ofmap_row_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_deskew_collector.sv
// Realigns column-skewed MAC outputs into row vectors, buffers them and tracks tile completion.
module ofmap_deskew_collector
  import ofmap_pkg::*;
#(
  parameter int unsigned MAC_COL        = MAC_COL_DEFAULT,
  parameter int unsigned OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int unsigned ROW_CNT_W      = ROW_CNT_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  ofmap_deskew_collector_if.slave       bus,
  input  logic                          tile_start_in,
  input  logic [ROW_CNT_W-1:0]          tile_rows_in,
  input  logic                          clear_flags_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tile_done,
  output logic                          skew_error,
  output logic                          overflow,
  output logic                          unexpected_row
);

  localparam int unsigned ROW_W = MAC_COL * OFMAP_BITWIDTH;

  logic [MAC_COL-1:0]                     aligned_valid;
  logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] aligned_data;

  // Column c is delayed MAC_COL-1-c cycles so all columns of one row line up.
  for (genvar c = 0; c < int'(MAC_COL); c++) begin : g_col
    localparam int unsigned STAGES = MAC_COL - 1 - c;
    if (STAGES == 0) begin : g_pass
      assign aligned_valid[c] = bus.ofmap_valid_in[c];
      assign aligned_data[c]  = bus.ofmap_data_in[c];
    end else begin : g_dly
      logic [STAGES-1:0]                     v_q;
      logic [STAGES-1:0][OFMAP_BITWIDTH-1:0] d_q;
      if (STAGES == 1) begin : g_one
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            v_q <= '0;
            d_q <= '0;
          end else begin
            v_q <= bus.ofmap_valid_in[c];
            d_q <= bus.ofmap_data_in[c];
          end
        end
      end else begin : g_many
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            v_q <= '0;
            d_q <= '0;
          end else begin
            v_q <= {v_q[STAGES-2:0], bus.ofmap_valid_in[c]};
            d_q <= {d_q[STAGES-2:0], bus.ofmap_data_in[c]};
          end
        end
      end
      assign aligned_valid[c] = v_q[STAGES-1];
      assign aligned_data[c]  = d_q[STAGES-1];
    end
  end

  logic             full_row;
  logic             part_row;
  logic             pop;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ROW_W-1:0] head_row;

  assign full_row     = &aligned_valid;
  assign part_row     = (|aligned_valid) & ~full_row;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = head_row;
  assign pop          = bus.out_valid & bus.out_ready;

  ofmap_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (aligned_data),
    .pop       (pop),
    .pop_data  (head_row),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  state_t               state;
  state_t               state_nxt;
  logic [ROW_CNT_W-1:0] rows_left;
  logic [ROW_CNT_W-1:0] rows_left_nxt;
  logic                 tile_done_nxt;
  logic                 ovf_evt;
  logic                 unexp_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rows_left      <= '0;
      tile_done      <= 1'b0;
      skew_error     <= 1'b0;
      overflow       <= 1'b0;
      unexpected_row <= 1'b0;
    end else begin
      state          <= state_nxt;
      rows_left      <= rows_left_nxt;
      tile_done      <= tile_done_nxt;
      skew_error     <= (skew_error & ~clear_flags_in) | part_row;
      overflow       <= (overflow & ~clear_flags_in) | ovf_evt;
      unexpected_row <= (unexpected_row & ~clear_flags_in) | unexp_evt;
    end
  end

  // Rows are only accepted while a tile is armed; pops count down the tile.
  always_comb begin
    state_nxt     = state;
    rows_left_nxt = rows_left;
    tile_done_nxt = 1'b0;
    push          = 1'b0;
    ovf_evt       = 1'b0;
    unexp_evt     = 1'b0;
    case (state)
      IDLE: begin
        unexp_evt = full_row;
        if (tile_start_in) begin
          if (tile_rows_in != '0) begin
            rows_left_nxt = tile_rows_in;
            state_nxt     = ACTIVE;
          end else begin
            tile_done_nxt = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (full_row) begin
          if (!fifo_full || pop) begin
            push = 1'b1;
          end else begin
            ovf_evt = 1'b1;
          end
        end
        if (pop) begin
          rows_left_nxt = rows_left - ROW_CNT_W'(1);
          if (rows_left == ROW_CNT_W'(1)) begin
            state_nxt     = DONE;
            tile_done_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ofmap_deskew_collector.sv
// Directed bench for the deskew collector with MAC_COL=4 and FIFO_DEPTH=4.
module tb_ofmap_deskew_collector;

  localparam int unsigned MAC_COL        = 4;
  localparam int unsigned OFMAP_BITWIDTH = 32;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned ROW_CNT_W      = 16;
  localparam int unsigned MAX_ROWS       = 16;

  logic                 clk;
  logic                 rst;
  logic                 tile_start_in;
  logic [ROW_CNT_W-1:0] tile_rows_in;
  logic                 clear_flags_in;
  logic [2:0]           fifo_count;
  logic                 tile_done;
  logic                 skew_error;
  logic                 overflow;
  logic                 unexpected_row;

  ofmap_deskew_collector_if #(.MAC_COL(MAC_COL), .OFMAP_BITWIDTH(OFMAP_BITWIDTH)) bus ();

  ofmap_deskew_collector #(
    .MAC_COL        (MAC_COL),
    .OFMAP_BITWIDTH (OFMAP_BITWIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .ROW_CNT_W      (ROW_CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .tile_start_in  (tile_start_in),
    .tile_rows_in   (tile_rows_in),
    .clear_flags_in (clear_flags_in),
    .fifo_count     (fifo_count),
    .tile_done      (tile_done),
    .skew_error     (skew_error),
    .overflow       (overflow),
    .unexpected_row (unexpected_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_pass;
  int          cyc;
  int          n_rows;
  int          r_start [MAX_ROWS];
  logic [31:0] r_base  [MAX_ROWS];
  logic [3:0]  r_mask  [MAX_ROWS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [127:0] exp_row(input logic [31:0] base);
    logic [3:0][31:0] r;
    for (int c = 0; c < 4; c++) r[c] = base + 32'(c);
    return r;
  endfunction

  task automatic add_row(input int start, input logic [31:0] base, input logic [3:0] mask);
    r_start[n_rows] = start;
    r_base[n_rows]  = base;
    r_mask[n_rows]  = mask;
    n_rows++;
  endtask

  // Column c carries row r during cycle r_start[r]+c.
  task automatic drive_cols();
    logic [3:0]       v;
    logic [3:0][31:0] d;
    v = '0;
    d = '0;
    for (int r = 0; r < n_rows; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (cyc == r_start[r] + c && r_mask[r][c]) begin
          v[c] = 1'b1;
          d[c] = r_base[r] + 32'(c);
        end
      end
    end
    bus.ofmap_valid_in = v;
    bus.ofmap_data_in  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_cols();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic start_tile(input logic [15:0] rows);
    tile_start_in = 1'b1;
    tile_rows_in  = rows;
    tick();
    tile_start_in = 1'b0;
    tile_rows_in  = '0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    n_rows        = 0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    n_rows   = 0;
    rst            = 1'b1;
    tile_start_in  = 1'b0;
    tile_rows_in   = '0;
    clear_flags_in = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ofmap_valid_in = '0;
    bus.ofmap_data_in  = '0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_data", 128'(bus.out_data), 128'd0);
    check("rst_count", 128'(fifo_count), 128'd0);
    check("rst_flags", 128'({tile_done, skew_error, overflow, unexpected_row}), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single-row tile: latency, data order, tile_done pulse.
    start_tile(16'd1);
    s = cyc + 1;
    add_row(s, 32'h10, 4'hF);
    run_to(s + 3);
    check("t1_not_yet_valid", 128'(bus.out_valid), 128'd0);
    tick();
    check("t1_valid", 128'(bus.out_valid), 128'd1);
    check("t1_data", 128'(bus.out_data), 128'h00000013_00000012_00000011_00000010);
    check("t1_count", 128'(fifo_count), 128'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t1_tile_done", 128'(tile_done), 128'd1);
    check("t1_empty", 128'(bus.out_valid), 128'd0);
    tick();
    check("t1_done_pulse_end", 128'(tile_done), 128'd0);

    // Six back-to-back rows into a depth-4 FIFO with no pops.
    start_tile(16'd6);
    s = cyc + 1;
    for (int k = 0; k < 6; k++) add_row(s + k, 32'h20 + 32'(k * 16), 4'hF);
    run_to(s + 7);
    check("t2_full_count", 128'(fifo_count), 128'd4);
    check("t2_no_ovf_yet", 128'(overflow), 128'd0);
    run_to(s + 9);
    check("t2_count_held", 128'(fifo_count), 128'd4);
    check("t2_overflow", 128'(overflow), 128'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_pop%0d", k), 128'(bus.out_data), exp_row(32'h20 + 32'(k * 16)));
      check($sformatf("t2_no_done%0d", k), 128'(tile_done), 128'd0);
      tick();
    end
    check("t2_drained", 128'(bus.out_valid), 128'd0);
    check("t2_never_done", 128'(tile_done), 128'd0);
    bus.out_ready = 1'b0;
    do_reset();
    check("t2_rst_overflow", 128'(overflow), 128'd0);

    // Column 2 missing: skew error, no push, then cleared.
    start_tile(16'd1);
    s = cyc + 1;
    add_row(s, 32'h80, 4'b1011);
    run_to(s + 4);
    check("t3_skew", 128'(skew_error), 128'd1);
    check("t3_no_push", 128'(fifo_count), 128'd0);
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
    check("t3_cleared", 128'(skew_error), 128'd0);
    do_reset();

    // Full FIFO popped in the same cycle a new row aligns.
    start_tile(16'd5);
    s = cyc + 1;
    for (int k = 0; k < 4; k++) add_row(s + k, 32'h100 + 32'(k * 16), 4'hF);
    add_row(s + 5, 32'h140, 4'hF);
    run_to(s + 7);
    check("t4_full", 128'(fifo_count), 128'd4);
    tick();
    check("t4_head0", 128'(bus.out_data), exp_row(32'h100));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t4_count_kept", 128'(fifo_count), 128'd4);
    check("t4_no_overflow", 128'(overflow), 128'd0);
    bus.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      check($sformatf("t4_order%0d", k), 128'(bus.out_data), exp_row(32'h100 + 32'(k * 16)));
      tick();
    end
    bus.out_ready = 1'b0;
    check("t4_tile_done", 128'(tile_done), 128'd1);
    check("t4_empty", 128'(bus.out_valid), 128'd0);
    tick();

    // Row while IDLE, then async reset with rows buffered.
    s = cyc + 1;
    add_row(s, 32'h200, 4'hF);
    run_to(s + 4);
    check("t5_unexpected", 128'(unexpected_row), 128'd1);
    check("t5_no_push", 128'(fifo_count), 128'd0);
    start_tile(16'd3);
    s = cyc + 1;
    add_row(s, 32'h300, 4'hF);
    add_row(s + 1, 32'h310, 4'hF);
    run_to(s + 5);
    check("t5_two_buffered", 128'(fifo_count), 128'd2);
    #1;
    rst = 1'b1;
    #1;
    check("t5_async_valid", 128'(bus.out_valid), 128'd0);
    check("t5_async_count", 128'(fifo_count), 128'd0);
    check("t5_async_flags", 128'({skew_error, overflow, unexpected_row}), 128'd0);
    n_rows = 0;
    tick();
    rst = 1'b0;
    tick();

    // Zero-row tile completes immediately.
    start_tile(16'd0);
    check("t6_done", 128'(tile_done), 128'd1);
    tick();
    check("t6_done_end", 128'(tile_done), 128'd0);
    check("t6_no_rows", 128'(bus.out_valid), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
